conv_result_collector: RTL and testbench

//  Receiving end of the conv engine output stream (dout/ovalid/done). Captures one feature map
//  (24x24 for state=0, 8x8 for state=1) into a local buffer and checks its size.

---
 rtl/bnn_conv_pkg.sv | 16 +
 rtl/conv_result_ram.sv | 24 ++
 rtl/conv_result_collector.sv | 183 ++++++++++++++++++
 tb/tb_conv_result_collector.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bnn_conv_pkg.sv
// Shared constants and types for the conv result collector.
// Layer geometry and the capture/drain FSM encoding.
package bnn_conv_pkg;

  localparam int DATA_W    = 32;
  localparam int CONV1_ROW = 24;
  localparam int CONV2_ROW = 8;
  localparam int CONV1_OUT = CONV1_ROW * CONV1_ROW;
  localparam int CONV2_OUT = CONV2_ROW * CONV2_ROW;

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } fsm_e;

endpackage

// File: rtl/conv_result_ram.sv
// Frame buffer for the collector.
// One write port with an asynchronous read port.
module conv_result_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 600,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_result_collector.sv
// Captures one conv feature map, checks its size, then
// replays it row-major on a valid/ready stream.
module conv_result_collector
  import bnn_conv_pkg::*;
#(
  parameter int DATA_W = bnn_conv_pkg::DATA_W,
  parameter int DEPTH  = 600,
  parameter int ADDR_W = 10,
  parameter int ROW0   = CONV1_ROW,
  parameter int ROW1   = CONV2_ROW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              state,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_last,
  output logic              out_last,
  output logic              busy,
  output logic [ADDR_W-1:0] frame_count,
  output logic              err_count,
  output logic              err_overflow,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DEP_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] EXP0  = ADDR_W'(ROW0 * ROW0);
  localparam logic [ADDR_W-1:0] EXP1  = ADDR_W'(ROW1 * ROW1);

  fsm_e              st_q, st_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] frame_count_q, frame_count_d;
  logic              lyr_q, lyr_d;
  logic              err_count_q, err_count_d;
  logic              err_ovf_q, err_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              out_row_last_q, out_row_last_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] cnt_next;
  logic [ADDR_W-1:0] rl;
  logic              accept;
  logic              wr_en;
  logic              load;
  logic              hs;
  logic              beat_last;
  logic              row_end;

  conv_result_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    st_d           = st_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    col_d          = col_q;
    frame_count_d  = frame_count_q;
    lyr_d          = lyr_q;
    err_count_d    = err_count_q;
    err_ovf_d      = err_ovf_q;
    out_valid_d    = out_valid_q;
    out_row_last_d = out_row_last_q;
    out_last_d     = out_last_q;
    out_data_d     = out_data_q;
    frame_done_d   = 1'b0;
    wr_en          = 1'b0;
    load           = 1'b0;
    accept    = in_valid && (wr_ptr_q < DEP_A);
    cnt_next  = accept ? wr_ptr_q + ONE : wr_ptr_q;
    hs        = out_valid_q && out_ready;
    rl        = lyr_q ? ADDR_W'(ROW1) : ADDR_W'(ROW0);
    beat_last = (rd_ptr_q == frame_count_q - ONE);
    row_end   = (col_q == rl - ONE);
    unique case (st_q)
      CAPTURE: begin
        // first beat of a new frame clears the sticky flags
        if (in_valid && wr_ptr_q == '0) begin
          err_count_d = 1'b0;
          err_ovf_d   = 1'b0;
        end
        if (accept) begin
          wr_en    = 1'b1;
          wr_ptr_d = cnt_next;
        end
        if (in_valid && !accept) err_ovf_d = 1'b1;
        if (in_done) begin
          frame_count_d = cnt_next;
          lyr_d         = state;
          err_count_d   = cnt_next != (state ? EXP1 : EXP0);
          if (cnt_next != '0) st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (in_valid || in_done) err_ovf_d = 1'b1;
        load = (!out_valid_q || out_ready) && (rd_ptr_q < frame_count_q);
        if (load) begin
          out_data_d     = rd_data;
          out_valid_d    = 1'b1;
          out_last_d     = beat_last;
          out_row_last_d = row_end || beat_last;
          col_d          = row_end ? '0 : col_q + ONE;
          rd_ptr_d       = rd_ptr_q + ONE;
        end else if (hs) begin
          out_valid_d = 1'b0;
        end
        if (hs && out_last_q) begin
          out_valid_d    = 1'b0;
          out_last_d     = 1'b0;
          out_row_last_d = 1'b0;
          frame_done_d   = 1'b1;
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
          col_d          = '0;
          st_d           = CAPTURE;
        end
      end
      default: st_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q           <= CAPTURE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      col_q          <= '0;
      frame_count_q  <= '0;
      lyr_q          <= 1'b0;
      err_count_q    <= 1'b0;
      err_ovf_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_row_last_q <= 1'b0;
      out_last_q     <= 1'b0;
      out_data_q     <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      st_q           <= st_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      col_q          <= col_d;
      frame_count_q  <= frame_count_d;
      lyr_q          <= lyr_d;
      err_count_q    <= err_count_d;
      err_ovf_q      <= err_ovf_d;
      out_valid_q    <= out_valid_d;
      out_row_last_q <= out_row_last_d;
      out_last_q     <= out_last_d;
      out_data_q     <= out_data_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row_last = out_row_last_q;
  assign out_last     = out_last_q;
  assign busy         = (st_q == DRAIN);
  assign frame_count  = frame_count_q;
  assign err_count    = err_count_q;
  assign err_overflow = err_ovf_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: directed frames with a
// queue-based reference of the expected replay stream.
module tb_conv_result_collector;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 600;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          state = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_done = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_row_last, out_last, busy;
  logic          err_count, err_overflow, frame_done;
  logic [AW-1:0] frame_count;

  int            passed = 0;
  int            total = 0;
  logic [DW-1:0] model [$];

  always #5 clk = ~clk;

  conv_result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_done      (in_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row_last (out_row_last),
    .out_last     (out_last),
    .busy         (busy),
    .frame_count  (frame_count),
    .err_count    (err_count),
    .err_overflow (err_overflow),
    .frame_done   (frame_done)
  );

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // mode 0: data=i, 1: data=-i, else random
  task automatic send_frame(int n, bit st, bit done_last, int mode);
    logic [DW-1:0] d;
    int cnt;
    int expn;
    model.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (mode)
        0:       d = DW'(i);
        1:       d = DW'(-i);
        default: d = $urandom();
      endcase
      in_valid = 1'b1;
      in_data  = d;
      state    = st;
      in_done  = done_last && (i == n - 1);
      if (i < DEPTH) model.push_back(d);
    end
    if (!done_last) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_done  = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_done  = 1'b0;
    cnt  = model.size();
    expn = st ? 64 : 576;
    chk("busy_after_done", DW'(busy), 1);
    chk("frame_count", DW'(frame_count), DW'(cnt));
    chk("err_count", DW'(err_count), DW'(cnt != expn));
    chk("err_overflow", DW'(err_overflow), DW'(n > DEPTH));
    chk("first_valid_latency", DW'(out_valid), 0);
  endtask

  task automatic drain(bit st, bit rand_ready, int stop_at, bit inject);
    int beats = 0;
    int fd = 0;
    int n = model.size();
    int rl = st ? 8 : 24;
    int target = (stop_at > 0) ? stop_at : n;
    int budget = n * 8 + 100;
    logic stalled = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic hold_rl = 1'b0;
    logic hold_l = 1'b0;
    while (beats < target && budget > 0) begin
      @(negedge clk);
      budget--;
      in_valid = inject && (beats == 10);
      if (stalled) begin
        chk("stall_valid", DW'(out_valid), 1);
        chk("stall_data", out_data, hold_d);
        chk("stall_row_last", DW'(out_row_last), DW'(hold_rl));
        chk("stall_last", DW'(out_last), DW'(hold_l));
      end
      if (frame_done) fd++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = out_valid && !out_ready;
      hold_d  = out_data;
      hold_rl = out_row_last;
      hold_l  = out_last;
      if (out_valid && out_ready) begin
        chk("data", out_data, model[beats]);
        chk("row_last", DW'(out_row_last),
            DW'((beats % rl == rl - 1) || (beats == n - 1)));
        chk("last", DW'(out_last), DW'(beats == n - 1));
        beats++;
      end
    end
    in_valid = 1'b0;
    chk("handshakes", DW'(beats), DW'(target));
    if (stop_at == 0) begin
      repeat (3) begin
        @(negedge clk);
        if (frame_done) fd++;
      end
      chk("frame_done_once", DW'(fd), 1);
      chk("valid_after_frame", DW'(out_valid), 0);
      chk("busy_after_frame", DW'(busy), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_frame_count", DW'(frame_count), 0);
    chk("rst_err_count", DW'(err_count), 0);
    chk("rst_err_overflow", DW'(err_overflow), 0);
    chk("rst_frame_done", DW'(frame_done), 0);
    chk("rst_out_last", DW'(out_last), 0);
    chk("rst_out_row_last", DW'(out_row_last), 0);
    rst = 1'b0;

    send_frame(576, 1'b0, 1'b1, 0);
    drain(1'b0, 1'b0, 0, 1'b0);

    send_frame(64, 1'b1, 1'b1, 1);
    drain(1'b1, 1'b0, 0, 1'b0);

    send_frame(576, 1'b0, 1'b1, 0);
    drain(1'b0, 1'b1, 0, 1'b0);

    send_frame(500, 1'b0, 1'b0, 2);
    drain(1'b0, 1'b1, 0, 1'b0);

    send_frame(605, 1'b0, 1'b1, 2);
    drain(1'b0, 1'b1, 0, 1'b1);
    chk("ovf_sticky_after_drain", DW'(err_overflow), 1);
    chk("count_err_sticky", DW'(err_count), 1);
    send_frame(64, 1'b1, 1'b1, 2);
    drain(1'b1, 1'b1, 0, 1'b0);

    send_frame(576, 1'b0, 1'b1, 2);
    drain(1'b0, 1'b0, 100, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", DW'(out_valid), 0);
    chk("midrst_busy", DW'(busy), 0);
    chk("midrst_frame_count", DW'(frame_count), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    send_frame(64, 1'b1, 1'b1, 2);
    drain(1'b1, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
